// File: rtl/logic_result_stage.sv
// logic_result_stage
// Registered output stage behind logicUnit in the 4-bit ALU. It selects the
// AND/OR/XOR result requested by a one-hot opCode and computes zero, parity
// and illegal-op flags. Each result is queued in a small FIFO with a
// valid/ready handshake on both sides. A counter tracks accepted operations.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   inValid / inReady              upstream handshake
//   opCode                         one-hot op: 001 AND, 010 OR, 100 XOR
//   resultA / resultO / resultX    parallel logic results
//   outValid / outReady            downstream handshake
//   outData, outOp                 head entry data and its opCode
//   outZero, outParity, outOpErr   head entry flags
//   opCount                        accepted entries, modulo 2^CNT_W
module logic_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       opCode,
    input  logic [WIDTH-1:0] resultA,
    input  logic [WIDTH-1:0] resultO,
    input  logic [WIDTH-1:0] resultX,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [2:0]       outOp,
    output logic             outZero,
    output logic             outParity,
    output logic             outOpErr,
    output logic [CNT_W-1:0] opCount
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [2:0]       op;
        logic             zero;
        logic             parity;
        logic             op_err;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_op_cnt;

    entry_t             w_entry;
    logic               w_push;
    logic               w_pop;
    logic [OCC_W-1:0]   w_occ_nxt;

    assign w_push = inValid & r_in_ready;
    assign w_pop  = r_out_valid & outReady;

    // Result select and flags; an illegal opCode stores data 0 with op_err set.
    always_comb begin
        w_entry        = '0;
        w_entry.op     = opCode;
        case (opCode)
            3'b001:  w_entry.data = resultA;
            3'b010:  w_entry.data = resultO;
            3'b100:  w_entry.data = resultX;
            default: w_entry.op_err = 1'b1;
        endcase
        w_entry.zero   = (w_entry.data == '0);
        w_entry.parity = ^w_entry.data;
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (w_pop && !w_push) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    // Pointers, occupancy and handshake flags; flags are registered so that
    // inReady never depends combinationally on outReady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ       <= w_occ_nxt;
            r_in_ready  <= (w_occ_nxt < OCC_W'(DEPTH));
            r_out_valid <= (w_occ_nxt != '0);
        end
    end

    // Entry storage; cleared on reset so the head reads as all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign inReady   = r_in_ready;
    assign outValid  = r_out_valid;
    assign outData   = r_mem[r_rd_ptr].data;
    assign outOp     = r_mem[r_rd_ptr].op;
    assign outZero   = r_mem[r_rd_ptr].zero;
    assign outParity = r_mem[r_rd_ptr].parity;
    assign outOpErr  = r_mem[r_rd_ptr].op_err;
    assign opCount   = r_op_cnt;

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed testbench for logic_result_stage. Inputs are driven and outputs
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_logic_result_stage;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic       inReady;
    logic [2:0] opCode;
    logic [3:0] resultA;
    logic [3:0] resultO;
    logic [3:0] resultX;
    logic       outValid;
    logic       outReady;
    logic [3:0] outData;
    logic [2:0] outOp;
    logic       outZero;
    logic       outParity;
    logic       outOpErr;
    logic [7:0] opCount;

    int n_vec;
    int n_err;

    logic_result_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .opCode    (opCode),
        .resultA   (resultA),
        .resultO   (resultO),
        .resultX   (resultX),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outOp     (outOp),
        .outZero   (outZero),
        .outParity (outParity),
        .outOpErr  (outOpErr),
        .opCount   (opCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] o, input logic [3:0] x);
        inValid = v;
        opCode  = op;
        resultA = a;
        resultO = o;
        resultX = x;
    endtask

    task automatic head(input string tag, input logic v, input logic [3:0] d,
                        input logic [2:0] op, input logic z, input logic p, input logic e);
        check({tag, ".valid"},  32'(outValid),  32'(v));
        check({tag, ".data"},   32'(outData),   32'(d));
        check({tag, ".op"},     32'(outOp),     32'(op));
        check({tag, ".zero"},   32'(outZero),   32'(z));
        check({tag, ".parity"}, 32'(outParity), 32'(p));
        check({tag, ".operr"},  32'(outOpErr),  32'(e));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        outReady = 1'b0;
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);

        // Reset state
        repeat (2) @(negedge clk);
        head("rst", 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("rst.inready", 32'(inReady), 32'd1);
        check("rst.count",   32'(opCount), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic AND
        outReady = 1'b1;
        drive(1'b1, 3'b001, 4'b0001, 4'b0011, 4'b0010);
        @(negedge clk);
        head("and", 1'b1, 4'b0001, 3'b001, 1'b0, 1'b1, 1'b0);
        check("and.count", 32'(opCount), 32'd1);
        drive(1'b0, 3'b001, 4'b0001, 4'b0011, 4'b0010);
        @(negedge clk);
        check("and.drain", 32'(outValid), 32'd0);
        check("and.inready", 32'(inReady), 32'd1);

        // OR then XOR back to back
        drive(1'b1, 3'b010, 4'b0000, 4'b1101, 4'b0000);
        @(negedge clk);
        head("or", 1'b1, 4'b1101, 3'b010, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b100, 4'b1111, 4'b1111, 4'b0000);
        @(negedge clk);
        head("xor", 1'b1, 4'b0000, 3'b100, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("xor.drain", 32'(outValid), 32'd0);
        check("xor.count", 32'(opCount), 32'd3);

        // Backpressure and full
        outReady = 1'b0;
        drive(1'b1, 3'b001, 4'b0001, 4'b0000, 4'b0000);
        @(negedge clk);
        check("bp1.inready", 32'(inReady), 32'd1);
        drive(1'b1, 3'b010, 4'b0000, 4'b1111, 4'b0000);
        @(negedge clk);
        check("bp2.inready", 32'(inReady), 32'd0);
        drive(1'b1, 3'b100, 4'b0000, 4'b0000, 4'b1001);
        @(negedge clk);
        check("bp3.inready", 32'(inReady), 32'd0);
        check("bp3.count",   32'(opCount), 32'd5);
        head("bp3.hold", 1'b1, 4'b0001, 3'b001, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);
        outReady = 1'b1;
        @(negedge clk);
        head("bp.pop1", 1'b1, 4'b1111, 3'b010, 1'b0, 1'b0, 1'b0);
        check("bp.pop1.inready", 32'(inReady), 32'd1);
        @(negedge clk);
        check("bp.pop2", 32'(outValid), 32'd0);

        // Illegal opCodes
        drive(1'b1, 3'b011, 4'b0101, 4'b0111, 4'b0010);
        @(negedge clk);
        head("ill011", 1'b1, 4'b0000, 3'b011, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 4'b0101, 4'b0111, 4'b0010);
        @(negedge clk);
        head("ill000", 1'b1, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("ill.count", 32'(opCount), 32'd7);

        // Streaming: one XOR entry per cycle, each visible the cycle after push
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'b100, 4'h0, 4'h0, 4'(i));
            @(negedge clk);
            check("stream.data", 32'(outData), 32'(i % 16));
            check("stream.inready", 32'(inReady), 32'd1);
        end
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("stream.drain", 32'(outValid), 32'd0);
        // 7 earlier pushes + 300 = 307, modulo 256 = 51
        check("stream.count", 32'(opCount), 32'd51);

        // Async reset with two entries buffered
        outReady = 1'b0;
        drive(1'b1, 3'b001, 4'b1010, 4'h0, 4'h0);
        @(negedge clk);
        drive(1'b1, 3'b010, 4'h0, 4'b0110, 4'h0);
        @(negedge clk);
        drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0);
        check("ar.pre.full", 32'(inReady), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid",   32'(outValid), 32'd0);
        check("ar.count",   32'(opCount),  32'd0);
        check("ar.inready", 32'(inReady),  32'd1);
        check("ar.data",    32'(outData),  32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        check("ar.post1", 32'(outValid), 32'd0);
        @(negedge clk);
        check("ar.post2", 32'(outValid), 32'd0);
        check("ar.post.count", 32'(opCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
